div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage sequencer that issues DIV/DIVU/REM/REMU to the shared 32-cycle sequential divider and returns an architecturally correct RV32M result to the pipeline.
- Acts as the initiator side of the divider's level-enable/done-pulse interface.
- Stalls the pipeline while a division is in flight.
- Resolves RISC-V corner cases (divide-by-zero, signed overflow, remainder sign) locally, without engaging the divider for those cases.

Parameters:
- TIMEOUT_CYC, 40, max BUSY cycles waiting for div_done before forcing an error completion; must exceed divider latency.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX holds a divide-class instruction; operands held stable while stall=1
- req_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- flush  in  1  kill in-flight op (branch/trap)
- stall  out  1  freeze IF/ID/EX
- result_valid  out  1  one-cycle pulse; result valid
- result  out  32  rd write data
- timeout_err  out  1  sticky; set on watchdog expiry
- div_enable  out  1  divider level enable
- div_sign_sel  out  1  0 signed, 1 unsigned
- div_numA  out  32  dividend to divider
- div_denB  out  32  divisor to divider
- div_done  in  1  divider completion pulse
- div_quotient  in  32  divider quotient
- div_remainder  in  32  divider remainder

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - stall, result_valid, div_enable, timeout_err, div_sign_sel = 0.
  - result, div_numA, div_denB = 0.
  - Watchdog counter = 0.
  - Asserting reset mid-operation aborts immediately; div_enable drops asynchronously.
- FSM states:
  - IDLE:
    - On req_valid, latch funct3/rs1/rs2.
    - If rs2==0: go to RESP. Result = 0xFFFFFFFF (DIV/DIVU) or rs1 (REM/REMU).
    - Else if signed (funct3[0]=0), rs1==0x80000000 and rs2==0xFFFFFFFF: go to RESP. Result = 0x80000000 (DIV) or 0 (REM).
    - Otherwise: go to BUSY with div_enable<=1, div_sign_sel<=funct3[0], div_numA/div_denB<=rs1/rs2, watchdog<=0.
  - BUSY:
    - div_enable held at 1 and operands held constant. Watchdog increments each cycle.
    - On div_done: capture the result, div_enable<=0, go to RESP.
    - On watchdog==TIMEOUT_CYC-1: div_enable<=0, result<=0, timeout_err<=1, go to RESP.
  - RESP:
    - result_valid=1 for exactly this cycle, then go to IDLE.
    - div_enable is 0 in RESP, which guarantees at least one enable-low cycle before the next issue.
- Stall: stall = req_valid & (state != RESP), combinational.
  - The cycle that presents result_valid is the cycle the pipeline advances.
- Result fixup (signed ops only):
  - The divider negates both outputs when operand signs differ.
  - Controller recovers magnitudes: q_mag = neg ? -div_quotient : div_quotient; r_mag likewise, where neg = rs1[31]^rs2[31].
  - DIV result = neg ? -q_mag : q_mag.
  - REM result = rs1[31] ? -r_mag : r_mag.
  - Unsigned ops pass div_quotient / div_remainder through unchanged.
- Flush: in any state, flush=1 forces IDLE at the next edge with div_enable<=0 and no result_valid.
  - flush has priority over div_done in the same cycle.
- Back-to-back ops: a request present on the cycle after RESP is accepted from IDLE normally.
- Widths: all arithmetic is 32-bit two's complement; negation is ~x+1 with wrap (0x80000000 maps to itself).

Optional Feature:
- Macro DIV_RESULT_CACHE_EN.
- Defined:
  - Keep the last completed non-special signed/unsigned pair {sign_sel, rs1, rs2} plus q_mag and r_mag, with a valid bit.
  - An IDLE request matching the stored entry goes directly to RESP with the fixed-up result (2-cycle op), and the divider is not enabled.
  - The valid bit is cleared by reset and by timeout. Flush does not clear it.
- Undefined: every non-special op goes through BUSY.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> BUSY until div_done; result_valid with result=0xFFFFFFFD (-3). REM same operands -> result=0xFFFFFFFF (-1).
- DIVU rs1=0xFFFFFFFE, rs2=7 -> result 0x24924924. REMU same operands -> result 2. div_sign_sel=1 throughout BUSY.
- DIV/REM rs2=0, rs1=0x1234 -> RESP on the next cycle, div_enable never asserts. DIV gives 0xFFFFFFFF, REM gives 0x1234.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of same operands -> 0. Divider never enabled.
- Flush in the 10th BUSY cycle -> div_enable low on the next edge, no result_valid, state IDLE. A new DIVU 100/10 is then accepted and returns 10.
- Divider model that never pulses done -> div_enable drops after TIMEOUT_CYC=40 cycles, result=0, timeout_err stays 1. Under DIV_RESULT_CACHE_EN: DIV 100/7 followed by REM 100/7 -> second op completes in 2 cycles with result 2 and no div_enable.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the shared sequential divider (RV32M DIV/DIVU/REM/REMU).
// Optional result reuse of the last divider result is enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYC = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        timeout_err,
    output logic        div_enable,
    output logic        div_sign_sel,
    output logic [31:0] div_numA,
    output logic [31:0] div_denB,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [WD_W-1:0]   wd_r;
    logic [1:0]        f3_r;

    logic              accept_s;
    logic              div0_s;
    logic              ovf_s;
    logic [31:0]       special_result_s;
    logic [31:0]       q_mag_s;
    logic [31:0]       r_mag_s;
    logic [31:0]       busy_result_s;
    logic              done_s;
    logic              timeout_s;
    logic              hit_s;
    logic [31:0]       hit_result_s;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // The divider returns sign-adjusted outputs for signed ops with differing operand signs.
    function automatic logic [31:0] mag_of(input logic is_signed, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] x);
        logic [31:0] m;
        if (is_signed && (a[31] ^ b[31])) begin
            m = neg32(x);
        end else begin
            m = x;
        end
        return m;
    endfunction

    function automatic logic [31:0] fixup(input logic is_unsigned, input logic is_rem,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] qm, input logic [31:0] rm);
        logic [31:0] res;
        if (is_unsigned) begin
            res = is_rem ? rm : qm;
        end else if (is_rem) begin
            res = a[31] ? neg32(rm) : rm;
        end else begin
            res = (a[31] ^ b[31]) ? neg32(qm) : qm;
        end
        return res;
    endfunction

`ifdef DIV_RESULT_CACHE_EN
    logic        cache_valid_r;
    logic        cache_sign_r;
    logic [31:0] cache_rs1_r;
    logic [31:0] cache_rs2_r;
    logic [31:0] cache_q_r;
    logic [31:0] cache_r_r;
`endif

    // Request decode, corner-case results and divider result fixup
    always_comb begin
        accept_s         = req_valid & req_funct3[2];
        div0_s           = (req_rs2 == 32'd0);
        ovf_s            = ~req_funct3[0] & (req_rs1 == 32'h8000_0000) & (req_rs2 == 32'hFFFF_FFFF);
        special_result_s = 32'd0;
        if (div0_s) begin
            special_result_s = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
        end else begin
            special_result_s = req_funct3[1] ? 32'd0 : 32'h8000_0000;
        end
        q_mag_s       = mag_of(~f3_r[0], div_numA, div_denB, div_quotient);
        r_mag_s       = mag_of(~f3_r[0], div_numA, div_denB, div_remainder);
        busy_result_s = fixup(f3_r[0], f3_r[1], div_numA, div_denB, q_mag_s, r_mag_s);
        done_s        = (state_r == BUSY) & ~flush & div_done;
        timeout_s     = (state_r == BUSY) & ~flush & ~div_done & (wd_r == WD_W'(TIMEOUT_CYC - 1));
        stall         = req_valid & (state_r != RESP);
`ifdef DIV_RESULT_CACHE_EN
        hit_s         = cache_valid_r & (cache_sign_r == req_funct3[0]) &
                        (cache_rs1_r == req_rs1) & (cache_rs2_r == req_rs2);
        hit_result_s  = fixup(req_funct3[0], req_funct3[1], req_rs1, req_rs2, cache_q_r, cache_r_r);
`else
        hit_s         = 1'b0;
        hit_result_s  = 32'd0;
`endif
    end

`ifdef DIV_RESULT_CACHE_EN
    // Last completed divider operation, stored as magnitudes so DIV and REM can share it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid_r <= 1'b0;
            cache_sign_r  <= 1'b0;
            cache_rs1_r   <= 32'd0;
            cache_rs2_r   <= 32'd0;
            cache_q_r     <= 32'd0;
            cache_r_r     <= 32'd0;
        end else if (timeout_s) begin
            cache_valid_r <= 1'b0;
        end else if (done_s) begin
            cache_valid_r <= 1'b1;
            cache_sign_r  <= div_sign_sel;
            cache_rs1_r   <= div_numA;
            cache_rs2_r   <= div_denB;
            cache_q_r     <= q_mag_s;
            cache_r_r     <= r_mag_s;
        end else begin
            cache_valid_r <= cache_valid_r;
        end
    end
`endif

    // Issue/complete FSM with registered divider interface and result outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            result_valid <= 1'b0;
            result       <= 32'd0;
            timeout_err  <= 1'b0;
            div_enable   <= 1'b0;
            div_sign_sel <= 1'b0;
            div_numA     <= 32'd0;
            div_denB     <= 32'd0;
            wd_r         <= {WD_W{1'b0}};
            f3_r         <= 2'b00;
        end else if (flush) begin
            state_r      <= IDLE;
            result_valid <= 1'b0;
            div_enable   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (accept_s) begin
                        f3_r <= req_funct3[1:0];
                        if (div0_s || ovf_s) begin
                            state_r      <= RESP;
                            result_valid <= 1'b1;
                            result       <= special_result_s;
                        end else if (hit_s) begin
                            state_r      <= RESP;
                            result_valid <= 1'b1;
                            result       <= hit_result_s;
                        end else begin
                            state_r      <= BUSY;
                            div_enable   <= 1'b1;
                            div_sign_sel <= req_funct3[0];
                            div_numA     <= req_rs1;
                            div_denB     <= req_rs2;
                            wd_r         <= {WD_W{1'b0}};
                        end
                    end
                end
                BUSY: begin
                    wd_r <= wd_r + WD_W'(1);
                    if (div_done) begin
                        result       <= busy_result_s;
                        div_enable   <= 1'b0;
                        result_valid <= 1'b1;
                        state_r      <= RESP;
                    end else if (timeout_s) begin
                        result       <= 32'd0;
                        timeout_err  <= 1'b1;
                        div_enable   <= 1'b0;
                        result_valid <= 1'b1;
                        state_r      <= RESP;
                    end
                end
                RESP: begin
                    result_valid <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    result_valid <= 1'b0;
                    div_enable   <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural 32-cycle divider model.
module tb_div_issue_ctrl;
    localparam int LAT = 32;
    localparam int TO  = 40;

    logic        clk = 1'b0;
    logic        reset_n, req_valid, flush, div_done;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2, div_quotient, div_remainder;
    logic        stall, result_valid, timeout_err, div_enable, div_sign_sel;
    logic [31:0] result, div_numA, div_denB;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] sb_q[$];
    logic        model_ok, expect_to, exp_sticky, prev_rv;
    int          dcnt;

    div_issue_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush), .stall(stall),
        .result_valid(result_valid), .result(result), .timeout_err(timeout_err),
        .div_enable(div_enable), .div_sign_sel(div_sign_sel), .div_numA(div_numA),
        .div_denB(div_denB), .div_done(div_done), .div_quotient(div_quotient),
        .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] neg(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // RISC-V architectural result
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            return op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        end
        return op[1] ? a % b : a / b;
    endfunction

    // Divider behaviour: magnitude divide, both outputs negated when signs differ
    function automatic logic [63:0] div_model(input logic uns, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        if (uns) return {a / b, a % b};
        ma = a[31] ? neg(a) : a;
        mb = b[31] ? neg(b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) return {neg(q), neg(r)};
        return {q, r};
    endfunction

    always @(posedge clk) begin
        div_done <= 1'b0;
        if (!div_enable) begin
            dcnt <= 0;
        end else begin
            dcnt <= dcnt + 1;
            if (dcnt == LAT - 1 && model_ok) begin
                div_done <= 1'b1;
                {div_quotient, div_remainder} <= div_model(div_sign_sel, div_numA, div_denB);
            end
        end
    end

    // Scoreboard consumer
    always @(negedge clk) begin
        if (reset_n && result_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_result_valid", 32'(result_valid), 32'd0);
            end else begin
                check_eq("result", result, sb_q[0][31:0]);
                check_eq("timeout_err", 32'(timeout_err), 32'(sb_q[0][32]));
                void'(sb_q.pop_front());
            end
            if (prev_rv) check_eq("rv_one_cycle", 32'(prev_rv), 32'd0);
        end
        prev_rv <= result_valid;
    end

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output int en_cyc, output logic sel_bad);
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        sb_q.push_back({exp_sticky | expect_to, expect_to ? 32'd0 : ref_res(f3[1:0], a, b)});
        #1;
        check_eq("stall_on_req", 32'(stall), 32'd1);
        cyc = 0; en_cyc = 0; sel_bad = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (div_enable) begin
                en_cyc++;
                if (div_sign_sel !== f3[0]) sel_bad = 1'b1;
            end
            if (result_valid) break;
        end
        if (!result_valid) check_eq("op_completion_bound", 32'd0, 32'd1);
        else check_eq("stall_released_in_resp", 32'(stall), 32'd0);
        req_valid = 1'b0;
    endtask

    logic [2:0]  n_f3[10] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b110};
    logic [31:0] n_a[10]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7, 32'd7,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] n_b[10]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                              32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    logic [2:0]  s_f3[6]  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] s_a[6]   = '{32'h1234, 32'h1234, 32'hFFFF_0000, 32'hFFFF_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] s_b[6]   = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        int   cyc, en, n, guard;
        logic sb;
        reset_n = 1'b0; req_valid = 1'b0; flush = 1'b0; req_funct3 = 3'b000;
        req_rs1 = 32'd0; req_rs2 = 32'd0; model_ok = 1'b1; expect_to = 1'b0; exp_sticky = 1'b0;
        div_done = 1'b0; div_quotient = 32'd0; div_remainder = 32'd0; prev_rv = 1'b0; dcnt = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_result_valid", 32'(result_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_eq("rst_div_enable", 32'(div_enable), 32'd0);
        check_eq("rst_div_sign_sel", 32'(div_sign_sel), 32'd0);
        check_eq("rst_div_numA", div_numA, 32'd0);
        check_eq("rst_div_denB", div_denB, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(n_f3[i], n_a[i], n_b[i], cyc, en, sb);
            check_eq("divider_used", 32'(en != 0), 32'd1);
            check_eq("sign_sel_in_busy", 32'(sb), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            do_op(s_f3[i], s_a[i], s_b[i], cyc, en, sb);
            check_eq("special_no_enable", 32'(en), 32'd0);
            check_eq("special_latency", 32'(cyc), 32'd1);
        end

        // Flush during the 10th BUSY cycle
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b101; req_rs1 = 32'd1000; req_rs2 = 32'd3;
        n = 0; guard = 0;
        while (n < 10 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (div_enable) n++;
        end
        check_eq("flush_reached_busy10", 32'(n), 32'd10);
        flush = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_enable_low", 32'(div_enable), 32'd0);
        check_eq("flush_no_result", 32'(result_valid), 32'd0);
        repeat (3) @(negedge clk);
        do_op(3'b101, 32'd100, 32'd10, cyc, en, sb);
        check_eq("post_flush_busy", 32'(en != 0), 32'd1);

        // Same operands DIV then REM
        do_op(3'b100, 32'd100, 32'd7, cyc, en, sb);
        do_op(3'b110, 32'd100, 32'd7, cyc, en, sb);
`ifdef DIV_RESULT_CACHE_EN
        check_eq("cache_hit_no_enable", 32'(en), 32'd0);
        check_eq("cache_hit_latency", 32'(cyc), 32'd1);
`else
        check_eq("no_cache_busy", 32'(en != 0), 32'd1);
`endif

        // Silent divider: watchdog expiry
        model_ok = 1'b0; expect_to = 1'b1;
        do_op(3'b100, 32'd1000, 32'd3, cyc, en, sb);
        check_eq("timeout_enable_cycles", 32'(en), 32'(TO));
        model_ok = 1'b1; expect_to = 1'b0; exp_sticky = 1'b1;
        do_op(3'b110, 32'd100, 32'd7, cyc, en, sb);
        check_eq("cache_cleared_by_timeout", 32'(en != 0), 32'd1);
        check_eq("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // Asynchronous reset during BUSY
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd50; req_rs2 = 32'd5;
        repeat (5) @(negedge clk);
        check_eq("busy_before_reset", 32'(div_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_enable", 32'(div_enable), 32'd0);
        check_eq("async_reset_timeout_err", 32'(timeout_err), 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1; exp_sticky = 1'b0;
        do_op(3'b100, 32'd50, 32'd5, cyc, en, sb);
        repeat (3) @(negedge clk);
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1);
    end
endmodule
